uart_alu_frame_ctrl: RTL and testbench
======================================

// Module: uart_alu_frame_ctrl
// PURPOSE
//  Frame controller between the UART RX/TX FIFOs and the ALU. Parametrised successor of the
//  8-bit byte interface: operands are NB_DATA bits wide, sent as NB_DATA/8 bytes each, LSB first.
//  Frame on RX: A bytes, then B bytes, then 1 opcode byte. The result is returned on TX as
//  NB_DATA/8 bytes, LSB first. Unsupported opcodes are rejected.
// PARAMETERS
//  NB_DATA       8          operand/result width; multiple of 8, 8..64
//  NB_OP         6          ALU opcode width (low bits of the opcode byte)
//  TIMEOUT_CLKS  1000000    inter-byte timeout in clocks (used only with UART_ALU_TIMEOUT_EN)
// PORTS
//  i_clk         in   1        clock
//  i_reset       in   1        asynchronous, active-low reset
//  i_rx_empty    in   1        RX FIFO empty
//  i_rx_data     in   8        RX FIFO head word (first-word-fall-through)
//  o_rd_uart     out  1        RX FIFO pop strobe, 1 cycle per byte
//  i_tx_full     in   1        TX FIFO full
//  o_tx_data     out  8        TX FIFO write data
//  o_wr_uart     out  1        TX FIFO push strobe, 1 cycle per byte
//  o_alu_a       out  NB_DATA  ALU operand A
//  o_alu_b       out  NB_DATA  ALU operand B
//  o_alu_op      out  NB_OP    ALU opcode
//  i_alu_result  in   NB_DATA  combinational ALU result
//  o_busy        out  1        high in every state except IDLE
//  o_error       out  1        1-cycle pulse on invalid opcode or timeout
// BEHAVIOUR
//  - Reset (i_reset=0, async): state IDLE, byte counter 0. All outputs 0.
//  - States: IDLE -> RX_A -> RX_B -> RX_OP -> EXEC -> TX -> IDLE.
//  - IDLE: on !i_rx_empty, move to RX_A. No pop occurs in IDLE.
//  - RX_x: in any cycle with !i_rx_empty:
//      o_rd_uart=1, i_rx_data is captured the same cycle, counter increments.
//  - Byte k of A lands in o_alu_a[8k+7:8k]; B is filled the same way.
//  - RX_A/RX_B exit after NB_DATA/8 bytes; the counter clears on each exit.
//  - RX_OP: a single byte is popped.
//      If it is in the supported set, o_alu_op <= byte[NB_OP-1:0] and go to EXEC.
//      Otherwise pulse o_error next cycle, go to IDLE, leave o_alu_op unchanged, no TX.
//  - EXEC: one cycle; i_alu_result is registered into the TX shift register.
//      Total latency from the opcode pop to the first o_wr_uart: 2 cycles if TX is not full.
//  - TX: in each cycle with !i_tx_full:
//      o_wr_uart=1, o_tx_data = result byte (LSB first), then shift.
//    With i_tx_full=1, o_wr_uart=0 and the byte is held; no byte is lost or duplicated.
//    After NB_DATA/8 writes, return to IDLE.
//  - o_alu_a/b/op hold their values until overwritten by the next frame.
//  - Width rules: arithmetic wraps modulo 2^NB_DATA inside the ALU. No carry byte is sent.
//  - RX bytes arriving during EXEC/TX stay in the RX FIFO; they are not popped until RX_A.
//  - Reset mid-frame: the partial frame is discarded and all outputs are cleared immediately.
// CONFIGURATION
//  UART_ALU_TIMEOUT_EN defined:
//    - An idle counter runs in RX_A (after byte 0), RX_B and RX_OP, cleared on every pop.
//    - Reaching TIMEOUT_CLKS-1 pulses o_error, discards the frame and goes to IDLE.
//  Not defined: no counter is built; the controller waits indefinitely for bytes.
//    o_error then pulses only for an invalid opcode.
// STRUCTURE
//  - Package uart_alu_pkg holds:
//      opcode localparams ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26,
//      SRA 0x03, SRL 0x02, NOR 0x27;
//      the state encoding; the function is_valid_op().
//  - One sub-module, uart_alu_timeout (loadable down-counter), is instantiated only under
//    UART_ALU_TIMEOUT_EN. The FSM and byte assembly stay in this module.
// TESTING (NB_DATA=16, FWFT FIFO models)
//  1 RX 34 12 01 00 20 (A+B) -> TX 35 12; o_busy high from the first pop to the last write.
//  2 RX 00 00 01 00 22 (A-B) -> TX FF FF (wrap-around).
//  3 RX 01 00 01 00 3F -> o_error 1 cycle, no o_wr_uart;
//      then RX F0 0F 0F 00 24 (A AND B) -> TX 00 00.
//  4 Hold i_tx_full=1 for 10 cycles after EXEC -> o_wr_uart=0 throughout;
//      after release, exactly 2 writes in LSB-first order.
//  5 Assert i_reset after both A bytes -> all outputs 0 in the same cycle;
//      a fresh full frame then returns the correct result.
//  6 Macro on, TIMEOUT_CLKS=100: send 1 byte, then nothing -> o_error at +100 cycles, then IDLE.
//    Macro off -> stays in RX_A, no o_error.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame controller:
// supported opcodes, FSM state encoding and the opcode validity check.
package uart_alu_pkg;

  localparam logic [7:0] ADD = 8'h20;
  localparam logic [7:0] SUB = 8'h22;
  localparam logic [7:0] AND = 8'h24;
  localparam logic [7:0] OR  = 8'h25;
  localparam logic [7:0] XOR = 8'h26;
  localparam logic [7:0] SRA = 8'h03;
  localparam logic [7:0] SRL = 8'h02;
  localparam logic [7:0] NOR = 8'h27;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX_A  = 3'd1,
    ST_RX_B  = 3'd2,
    ST_RX_OP = 3'd3,
    ST_EXEC  = 3'd4,
    ST_TX    = 3'd5
  } state_e;

  // The whole received byte must match one of the supported opcodes.
  function automatic logic is_valid_op(input logic [7:0] op_byte);
    case (op_byte)
      ADD, SUB, AND, OR, XOR, SRA, SRL, NOR: is_valid_op = 1'b1;
      default:                               is_valid_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_frame_ctrl_timeout.sv
// Inter-byte idle timer: loadable down-counter. Reloaded on every pop or
// while not enabled; expires once it has counted down to zero while enabled.
// Only instantiated when UART_ALU_TIMEOUT_EN is defined.
module uart_alu_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned NB_CNT = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [NB_CNT-1:0] cnt_q, cnt_d;

  // Next count: reload on activity or when idle, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i || !en_i) begin
      cnt_d = NB_CNT'(TIMEOUT_CLKS - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - NB_CNT'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= NB_CNT'(TIMEOUT_CLKS - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Frame controller between UART RX/TX FIFOs (first-word-fall-through) and an ALU.
// RX frame: A (NB_DATA/8 bytes, LSB first), B (same), one opcode byte.
// TX: the ALU result as NB_DATA/8 bytes, LSB first. Unsupported opcodes pulse o_error.
// Optional feature macro: UART_ALU_TIMEOUT_EN (inter-byte timeout of TIMEOUT_CLKS).
module uart_alu_frame_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int NB_OP        = 6,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_empty,
  input  logic [7:0]         i_rx_data,
  output logic               o_rd_uart,
  input  logic               i_tx_full,
  output logic [7:0]         o_tx_data,
  output logic               o_wr_uart,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy,
  output logic               o_error
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  state_e             state_q, state_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               err_q, err_d;
  logic               rd_s, wr_s, last_s, timeout_s;

  assign last_s = (cnt_q == NB_CNT'(NB_BYTES - 1));

`ifdef UART_ALU_TIMEOUT_EN
  logic to_en_s;

  // Timer runs only while waiting for a byte that belongs to a started frame.
  assign to_en_s = ((state_q == ST_RX_A) && (cnt_q != '0)) ||
                   (state_q == ST_RX_B) || (state_q == ST_RX_OP);

  uart_alu_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .clk_i    (i_clk),
    .rst_ni   (i_reset),
    .load_i   (rd_s),
    .en_i     (to_en_s),
    .expire_o (timeout_s)
  );
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CLKS > 0);
  assign timeout_s            = 1'b0;
`endif

  // Next-state, byte assembly, TX shifting and FIFO strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    err_d   = 1'b0;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!i_rx_empty) begin
          state_d = ST_RX_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RX_A, ST_RX_B: begin
        if (!i_rx_empty) begin
          rd_s = 1'b1;
          for (int k = 0; k < NB_BYTES; k++) begin
            if (cnt_q == NB_CNT'(k)) begin
              if (state_q == ST_RX_A) begin
                a_d[8*k +: 8] = i_rx_data;
              end else begin
                b_d[8*k +: 8] = i_rx_data;
              end
            end
          end
          if (last_s) begin
            cnt_d   = '0;
            state_d = (state_q == ST_RX_A) ? ST_RX_B : ST_RX_OP;
          end else begin
            cnt_d = cnt_q + NB_CNT'(1);
          end
        end else if (timeout_s) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_RX_OP: begin
        if (!i_rx_empty) begin
          rd_s = 1'b1;
          if (is_valid_op(i_rx_data)) begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = ST_EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RX_OP;
        end
      end
      ST_EXEC: begin
        tx_d    = i_alu_result;
        cnt_d   = '0;
        state_d = ST_TX;
      end
      ST_TX: begin
        if (!i_tx_full) begin
          wr_s = 1'b1;
          tx_d = tx_q >> 8;
          if (last_s) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + NB_CNT'(1);
          end
        end else begin
          state_d = ST_TX;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears every visible output.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
    end
  end

  assign o_rd_uart = rd_s;
  assign o_wr_uart = wr_s;
  assign o_tx_data = tx_q[7:0];
  assign o_alu_a   = a_q;
  assign o_alu_b   = b_q;
  assign o_alu_op  = op_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_error   = err_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Bench for uart_alu_frame_ctrl (NB_DATA=16) with FWFT FIFO models and a
// frame-level reference model: expected TX bytes come from the arithmetic of
// the whole A/B/opcode frame. Timeout expectations follow UART_ALU_TIMEOUT_EN.
module tb_uart_alu_frame_ctrl;

  localparam int NB_DATA = 16;
  localparam int NB_OP   = 6;
  localparam int NBY     = NB_DATA / 8;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b0;
  logic               i_rx_empty = 1'b1;
  logic [7:0]         i_rx_data = 8'h00;
  logic               i_tx_full = 1'b0;
  logic               o_rd_uart, o_wr_uart, o_busy, o_error;
  logic [7:0]         o_tx_data;
  logic [NB_DATA-1:0] o_alu_a, o_alu_b, i_alu_result;
  logic [NB_OP-1:0]   o_alu_op;
  logic [49:0]        outs_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, last_pop_cyc = 0, err_cnt = 0;
  bit stall_en = 1'b0, hold_full = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  int         wr_cyc[$];

  uart_alu_frame_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CLKS(100)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data),
    .o_rd_uart(o_rd_uart), .i_tx_full(i_tx_full), .o_tx_data(o_tx_data), .o_wr_uart(o_wr_uart),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .i_alu_result(i_alu_result),
    .o_busy(o_busy), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // Reference ALU behaviour for a whole opcode byte (also serves as the ALU stub).
  function automatic logic [NB_DATA-1:0] alu_ref(input logic [NB_DATA-1:0] a, b, input logic [7:0] op);
    case (op)
      8'h20:   return a + b;
      8'h22:   return a - b;
      8'h24:   return a & b;
      8'h25:   return a | b;
      8'h26:   return a ^ b;
      8'h03:   return NB_DATA'($signed(a) >>> b);
      8'h02:   return a >> b;
      8'h27:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic bit is_sup(input logic [7:0] op);
    return op inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
  endfunction

  assign i_alu_result = alu_ref(o_alu_a, o_alu_b, {2'b00, o_alu_op});
  assign outs_s = {o_rd_uart, o_wr_uart, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy, o_error};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  // FIFO models and protocol monitor: sample mid-cycle, act just after the edge.
  initial begin
    bit rd_seen, wr_seen;
    logic [7:0] wr_byte;
    forever begin
      @(negedge i_clk);
      cyc++;
      rd_seen = o_rd_uart;
      wr_seen = o_wr_uart;
      wr_byte = o_tx_data;
      if (o_error) err_cnt++;
      if (rd_seen || wr_seen) check_eq("busy_active", {63'd0, o_busy}, 64'd1);
      if (rd_seen) check_eq("pop_when_empty", {63'd0, i_rx_empty}, 64'd0);
      if (i_tx_full) check_eq("wr_while_full", {63'd0, wr_seen}, 64'd0);
      @(posedge i_clk);
      #1;
      if (rd_seen && rx_q.size() > 0) begin
        void'(rx_q.pop_front());
        last_pop_cyc = cyc;
      end
      if (wr_seen) begin
        tx_got.push_back(wr_byte);
        wr_cyc.push_back(cyc);
      end
      i_rx_empty = (rx_q.size() == 0);
      i_rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
      i_tx_full  = hold_full || (stall_en && ($urandom_range(0, 3) == 0));
    end
  end

  // Send one frame (bytes before index 'skip' already queued) and check its outcome.
  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                            input bit chk_lat, input int hold, input int skip);
    logic [7:0] fb [0:4];
    logic [NB_DATA-1:0] exp;
    logic [NB_OP-1:0] op_before;
    int n0, e0, w0, budget;
    bit valid;
    fb[0] = a[7:0]; fb[1] = a[15:8]; fb[2] = b[7:0]; fb[3] = b[15:8]; fb[4] = op;
    n0 = tx_got.size(); w0 = wr_cyc.size(); e0 = err_cnt;
    op_before = o_alu_op;
    valid = is_sup(op);
    if (hold > 0) hold_full = 1'b1;
    for (int i = skip; i < 5; i++) rx_q.push_back(fb[i]);
    if (hold > 0) begin
      tick(hold);
      check_eq("held_no_write", 64'(tx_got.size() - n0), 64'd0);
      check_eq("held_busy", {63'd0, o_busy}, 64'd1);
      hold_full = 1'b0;
    end
    budget = 0;
    while (budget < 400 && !(valid ? (tx_got.size() >= n0 + NBY) : (err_cnt > e0))) begin
      tick(1);
      budget++;
    end
    tick(3);
    check_eq("frame_done_in_budget", {63'd0, budget < 400}, 64'd1);
    check_eq("alu_a", 64'(o_alu_a), 64'(a));
    check_eq("alu_b", 64'(o_alu_b), 64'(b));
    if (valid) begin
      exp = alu_ref(a, b, op);
      check_eq("alu_op", 64'(o_alu_op), 64'(op[NB_OP-1:0]));
      check_eq("tx_count", 64'(tx_got.size() - n0), 64'(NBY));
      check_eq("no_error", 64'(err_cnt - e0), 64'd0);
      if (tx_got.size() >= n0 + NBY) begin
        check_eq("tx_byte0", 64'(tx_got[n0]), 64'(exp[7:0]));
        check_eq("tx_byte1", 64'(tx_got[n0 + 1]), 64'(exp[15:8]));
        if (chk_lat) check_eq("op_to_wr_latency", 64'(wr_cyc[w0] - last_pop_cyc), 64'd2);
      end
    end else begin
      check_eq("err_pulse_cycles", 64'(err_cnt - e0), 64'd1);
      check_eq("no_tx_on_error", 64'(tx_got.size() - n0), 64'd0);
      check_eq("alu_op_kept", 64'(o_alu_op), 64'(op_before));
    end
    check_eq("idle_after_frame", {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    int e0, budget;
    logic [7:0] op;
    logic [15:0] ra, rb;
    logic [7:0] valid_ops [0:7];
    valid_ops[0] = 8'h20; valid_ops[1] = 8'h22; valid_ops[2] = 8'h24; valid_ops[3] = 8'h25;
    valid_ops[4] = 8'h26; valid_ops[5] = 8'h03; valid_ops[6] = 8'h02; valid_ops[7] = 8'h27;

    i_reset = 1'b0;
    tick(3);
    check_eq("reset_outputs", 64'(outs_s), 64'd0);
    i_reset = 1'b1;
    tick(2);

    send_frame(16'h1234, 16'h0001, 8'h20, 1'b1, 0, 0);
    send_frame(16'h0000, 16'h0001, 8'h22, 1'b1, 0, 0);
    send_frame(16'h0001, 16'h0001, 8'h3F, 1'b0, 0, 0);
    send_frame(16'h0FF0, 16'h000F, 8'h24, 1'b1, 0, 0);
    send_frame(16'hBEEF, 16'h1111, 8'h26, 1'b0, 17, 0);

    // Reset after both A bytes: partial frame dropped, outputs cleared at once.
    rx_q.push_back(8'h34);
    rx_q.push_back(8'h12);
    budget = 0;
    while (rx_q.size() != 0 && budget < 50) begin
      tick(1);
      budget++;
    end
    tick(1);
    check_eq("pre_reset_alu_a", 64'(o_alu_a), 64'h1234);
    i_reset = 1'b0;
    #1;
    check_eq("reset_mid_frame", 64'(outs_s), 64'd0);
    tick(2);
    rx_q.delete();
    i_reset = 1'b1;
    tick(2);
    send_frame(16'h1234, 16'h0001, 8'h20, 1'b1, 0, 0);

    // One byte then silence.
    e0 = err_cnt;
    rx_q.push_back(8'h34);
    tick(150);
`ifdef UART_ALU_TIMEOUT_EN
    check_eq("timeout_error", 64'(err_cnt - e0), 64'd1);
    check_eq("timeout_idle", {63'd0, o_busy}, 64'd0);
    send_frame(16'h1234, 16'h0001, 8'h20, 1'b1, 0, 0);
`else
    check_eq("no_timeout_error", 64'(err_cnt - e0), 64'd0);
    check_eq("still_waiting", {63'd0, o_busy}, 64'd1);
    send_frame(16'h1234, 16'h0001, 8'h20, 1'b0, 0, 1);
`endif

    // Randomised frames with optional TX back-pressure.
    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        do op = 8'($urandom_range(0, 63)); while (is_sup(op));
      end else begin
        op = valid_ops[$urandom_range(0, 7)];
      end
      stall_en = ($urandom_range(0, 1) == 1);
      tick(1);
      send_frame(ra, rb, op, !stall_en, 0, 0);
      stall_en = 1'b0;
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
